jk_seq_driver: RTL and testbench
================================

# jk_seq_driver

Excitation driver for a bank of WIDTH asynchronous-reset JK flip-flops. It steps the bank through a programmed sequence of target states by deriving each flop's J/K from the current state (fed back as q_fb) and the next target state. After each step it checks that the bank reached the target. The block sits next to the JK flip-flop bank as its controlling end: it produces J/K, and the bank consumes them.

## Interface
Parameters:
- WIDTH, 4: number of JK flops driven; width of each sequence entry.
- DEPTH, 8: sequence table entries (power of 2, ≥2).
- PREF_TOGGLE, 0: 0 = set/reset encoding for state changes; 1 = toggle (J=K=1) encoding for state changes.

Ports:
- clk  in  1  single clock; the driven JK bank shares it.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  write table entry this cycle.
- load_addr  in  log2(DEPTH)  table write address.
- load_data  in  WIDTH  target state to store.
- len  in  log2(DEPTH)+1  number of steps to run; sampled on start.
- loop_en  in  1  restart at entry 0 after the last step; sampled on start.
- start  in  1  begin sequence (level, honoured in IDLE only).
- stop  in  1  abort sequence.
- q_fb  in  WIDTH  current Q of the JK bank.
- j_out  out  WIDTH  J inputs to the bank (registered).
- k_out  out  WIDTH  K inputs to the bank (registered).
- busy  out  1  high in DRIVE/CHECK.
- done  out  1  one-cycle pulse on completion of the last step.
- err  out  1  sticky mismatch flag; cleared by reset or by an accepted start.
- step_idx  out  log2(DEPTH)  index of the current target entry.

## Operation
- Table: DEPTH×WIDTH registers.
  - Written when load_en=1 and state is IDLE.
  - Writes are ignored while busy.
  - Reset clears all entries to 0.
- Per-bit excitation, from current bit c (q_fb) and target bit t:
  - c=0, t=0: J=0, K=0.
  - c=1, t=1: J=0, K=0.
  - c=0, t=1: J=1, K=0 (PREF_TOGGLE=0) or J=1, K=1 (PREF_TOGGLE=1).
  - c=1, t=0: J=0, K=1 (PREF_TOGGLE=0) or J=1, K=1 (PREF_TOGGLE=1).
- Effective length L = min(len, DEPTH).
- FSM states: IDLE, DRIVE, CHECK.
  - IDLE, start=1, L≥1: latch L and loop_en; clear err; idx=0; j/k ← excitation(q_fb, table[0]); go to DRIVE.
  - IDLE, start=1, L=0: done pulses next cycle; stay IDLE; j/k stay 0.
  - DRIVE (one cycle): j/k are valid at the bank's inputs, and the bank samples them at the closing edge. At that edge: j/k ← 0; go to CHECK.
  - CHECK, q_fb == table[idx] and idx < L−1: idx++; j/k ← excitation(q_fb, table[idx+1]); go to DRIVE.
  - CHECK, match and idx = L−1, loop_en=0: done=1 for one cycle; idx=0; go to IDLE.
  - CHECK, match and idx = L−1, loop_en=1: idx=0; j/k ← excitation(q_fb, table[0]); go to DRIVE; no done pulse.
  - CHECK, mismatch: err=1; j/k=0; idx held for debug; go to IDLE; no done pulse.
- stop in DRIVE or CHECK: at the next edge j/k=0, go to IDLE, no done, err unchanged. stop has priority over all other transitions; stop in IDLE has no effect.
- start while busy is ignored.

## Timing
- Reset values: j_out=0, k_out=0, busy=0, done=0, err=0, step_idx=0, state IDLE, table all 0.
- Reset mid-sequence clears everything immediately (asynchronous) and the bank sees J=K=0.
- Each step takes 2 cycles (DRIVE + CHECK), so a non-looping sequence of L steps runs 2L cycles from the first DRIVE to done.
- start is registered: the first DRIVE cycle is the cycle after start is sampled.
- j/k are 0 in every cycle except DRIVE. The bank therefore holds its state in IDLE and CHECK.
- busy is high exactly in DRIVE and CHECK cycles.
- done is asserted in the cycle after the final CHECK, coincident with busy=0.
- q_fb is sampled combinationally in the cycle it is used. Its bank must update only on the same clk edge.

## Test plan
- Count sequence: WIDTH=4, table = 1,2,3,…,8, len=8, bank model reset to 0, start → bank Q = 1..8 on successive CHECKs; done pulses at cycle 16 after first DRIVE; err=0.
- Encoding check with PREF_TOGGLE=1: Q=4'b0101, target 4'b1001 → in DRIVE, j_out=4'b1100 and k_out=4'b1100; with PREF_TOGGLE=0 → j_out=4'b1000, k_out=4'b0100.
- Mismatch: bank model forces bit0 stuck at 0, target 4'b0001 → err=1 after CHECK, state IDLE, no done, step_idx=0; a subsequent start clears err.
- Loop: len=2, loop_en=1, table 3,12 → bank alternates 3,12 indefinitely with no done; stop asserted in CHECK → IDLE next edge, j/k=0, busy=0.
- Boundaries: len=0 → done pulse, no J/K activity; len=15 with DEPTH=8 → 8 steps run; load_en during busy leaves the table unchanged (read back by rerunning).
- Asynchronous reset asserted mid-DRIVE → j_out=k_out=0, busy=0 immediately without waiting for a clock edge; table cleared.

Source files
------------

// File: rtl/jk_seq_driver_if.sv
// jk_seq_driver_if: J/K excitation link between the sequence driver and its JK flop bank.
//   j_out, k_out : J/K inputs to the bank, driven by the master (the driver)
//   q_fb         : current Q of the bank, driven by the slave (the bank)
interface jk_seq_driver_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic [WIDTH-1:0] q_fb;
    modport master (output j_out, k_out, input q_fb);
    modport slave (input j_out, k_out, output q_fb);
endinterface

// File: rtl/jk_seq_driver.sv
// jk_seq_driver: steps a JK flop bank through a programmed table of target states.
//   clk, reset          : clock shared with the bank; asynchronous active-high reset
//   load_en/addr/data   : table write port, honoured only while idle
//   len, loop_en        : step count (clamped to DEPTH) and loop mode, sampled on start
//   start, stop         : begin (idle only) / abort a sequence
//   bank                : J/K out to the bank, q_fb back from it
//   busy, done, err     : running, one-cycle completion pulse, sticky mismatch flag
//   step_idx            : index of the current target entry
module jk_seq_driver #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int PREF_TOGGLE = 0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic [AW:0]      len,
    input  logic             loop_en,
    input  logic             start,
    input  logic             stop,
    jk_seq_driver_if.master  bank,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [AW-1:0]    step_idx
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    state_t           state;
    logic [WIDTH-1:0] tbl [DEPTH];
    logic [AW:0]      l_reg;
    logic             loop_r;
    logic [AW:0]      len_eff;
    logic [AW-1:0]    nxt;
    logic             last;

    // Returns {J, K}; bits already at their target get J=K=0 so the bank holds them.
    function automatic logic [2*WIDTH-1:0] exc(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] t);
        return PREF_TOGGLE != 0 ? {c ^ t, c ^ t} : {~c & t, c & ~t};
    endfunction

    assign len_eff = len > DEPTH_W ? DEPTH_W : len;
    assign nxt     = step_idx + AW'(1);
    assign last    = {1'b0, step_idx} == l_reg - (AW + 1)'(1);
    assign busy    = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tbl <= '{default: '0};
        else if (load_en && state == IDLE)
            tbl[load_addr] <= load_data;
    end

    // J/K default to 0 every cycle; only transitions into DRIVE load an excitation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bank.j_out <= '0;
            bank.k_out <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            step_idx   <= '0;
            l_reg      <= '0;
            loop_r     <= 1'b0;
        end else begin
            done <= 1'b0;
            {bank.j_out, bank.k_out} <= '0;
            if (state != IDLE && stop) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && len_eff == '0) begin
                            done <= 1'b1;
                        end else if (start) begin
                            l_reg    <= len_eff;
                            loop_r   <= loop_en;
                            err      <= 1'b0;
                            step_idx <= '0;
                            {bank.j_out, bank.k_out} <= exc(bank.q_fb, tbl[0]);
                            state    <= DRIVE;
                        end
                    end
                    DRIVE: state <= CHECK;
                    CHECK: begin
                        if (bank.q_fb != tbl[step_idx]) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else if (!last) begin
                            step_idx <= nxt;
                            {bank.j_out, bank.k_out} <= exc(bank.q_fb, tbl[nxt]);
                            state    <= DRIVE;
                        end else if (loop_r) begin
                            step_idx <= '0;
                            {bank.j_out, bank.k_out} <= exc(bank.q_fb, tbl[0]);
                            state    <= DRIVE;
                        end else begin
                            step_idx <= '0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jk_seq_driver.sv
// tb_jk_seq_driver: drives two drivers (set/reset and toggle encodings) against JK bank models.
module tb_jk_seq_driver;
    typedef struct packed {
        logic [3:0] j0, k0, j1, k1, q0, q1;
        logic       busy, done, err;
        logic [2:0] idx;
    } smp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_en = 1'b0;
    logic [2:0] load_addr = '0;
    logic [3:0] load_data = '0;
    logic [3:0] len = '0;
    logic       loop_en = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       busy0, done0, err0, busy1, done1, err1;
    logic [2:0] idx0, idx1;
    logic [3:0] q0, q1;
    logic       bank_set = 1'b1;
    logic [3:0] bank_val = '0;
    logic [3:0] stuck = '0;
    logic [3:0] tbl_m [8];
    smp_t       tr[$];
    smp_t       exq[$];
    int         tests = 0;
    int         fails = 0;

    jk_seq_driver_if #(.WIDTH(4)) bif0 ();
    jk_seq_driver_if #(.WIDTH(4)) bif1 ();

    jk_seq_driver #(.WIDTH(4), .DEPTH(8), .PREF_TOGGLE(0)) dut0 (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .len(len), .loop_en(loop_en), .start(start), .stop(stop), .bank(bif0.master),
        .busy(busy0), .done(done0), .err(err0), .step_idx(idx0));

    jk_seq_driver #(.WIDTH(4), .DEPTH(8), .PREF_TOGGLE(1)) dut1 (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .len(len), .loop_en(loop_en), .start(start), .stop(stop), .bank(bif1.master),
        .busy(busy1), .done(done1), .err(err1), .step_idx(idx1));

    always #5 clk = ~clk;

    assign bif0.q_fb = q0;
    assign bif1.q_fb = q1;

    // JK bank models: Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits and a direct preset.
    always @(posedge clk) begin
        q0 <= bank_set ? bank_val : ((bif0.j_out & ~q0) | (~bif0.k_out & q0)) & ~stuck;
        q1 <= bank_set ? bank_val : ((bif1.j_out & ~q1) | (~bif1.k_out & q1)) & ~stuck;
    end

    function automatic logic [3:0] jx(input logic [3:0] c, input logic [3:0] t, input bit p);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (c[i] != t[i]) && (p || t[i]);
        return r;
    endfunction

    function automatic logic [3:0] kx(input logic [3:0] c, input logic [3:0] t, input bit p);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (c[i] != t[i]) && (p || !t[i]);
        return r;
    endfunction

    // Expected trace from the first DRIVE cycle: even cycles drive toward step c/2,
    // odd cycles show the bank at that target, done one cycle after the last check.
    function automatic void build(input int ln, input bit lp, input logic [3:0] qi, input int n);
        int l;
        int s;
        logic [3:0] q;
        smp_t e;
        l = ln > 8 ? 8 : ln;
        q = qi;
        exq.delete();
        for (int c = 0; c < n; c++) begin
            e = '0;
            if (lp || c < 2 * l) begin
                s = (c / 2) % l;
                e.busy = 1'b1;
                e.idx = 3'(s);
                if (c % 2 == 0) begin
                    e.j0 = jx(q, tbl_m[s], 1'b0);
                    e.k0 = kx(q, tbl_m[s], 1'b0);
                    e.j1 = jx(q, tbl_m[s], 1'b1);
                    e.k1 = kx(q, tbl_m[s], 1'b1);
                end else begin
                    q = tbl_m[s];
                end
            end else begin
                e.done = (c == 2 * l);
            end
            e.q0 = q;
            e.q1 = q;
            exq.push_back(e);
        end
    endfunction

    function automatic smp_t smp();
        smp_t s;
        s.j0 = bif0.j_out; s.k0 = bif0.k_out; s.j1 = bif1.j_out; s.k1 = bif1.k_out;
        s.q0 = q0; s.q1 = q1; s.busy = busy0; s.done = done0; s.err = err0; s.idx = idx0;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [3:0] d);
        load_en = 1'b1; load_addr = 3'(a); load_data = d;
        tick();
        load_en = 1'b0;
        tbl_m[a] = d;
    endtask

    task automatic set_bank(input logic [3:0] v);
        bank_set = 1'b1; bank_val = v;
        tick();
        bank_set = 1'b0;
    endtask

    task automatic kick(input int ln, input bit lp);
        start = 1'b1; len = 4'(ln); loop_en = lp;
        tick();
        start = 1'b0;
    endtask

    task automatic capture(input int n);
        tr.delete();
        for (int i = 0; i < n; i++) begin
            tr.push_back(smp());
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        tests++;
        if ({bif0.j_out, bif0.k_out, busy0, done0, err0, idx0} !== 14'b0) begin
            fails++;
            $display("FAIL reset_dut0: got %h expected 0", {bif0.j_out, bif0.k_out, busy0, done0, err0, idx0});
        end
        tests++;
        if ({bif1.j_out, bif1.k_out, busy1} !== 9'b0) begin
            fails++;
            $display("FAIL reset_dut1: got %h expected 0", {bif1.j_out, bif1.k_out, busy1});
        end
        @(negedge clk);
        reset = 1'b0;
        bank_set = 1'b0;
        tick();
    endtask

    task automatic test_encoding();
        load(0, 4'b1001);
        set_bank(4'b0101);
        kick(1, 0);
        capture(4);
        build(1, 0, 4'b0101, 4);
        tests++;
        if ({tr[0].j0, tr[0].k0, tr[0].j1, tr[0].k1} !== 16'b1000_0100_1100_1100) begin
            fails++;
            $display("FAIL encoding: got %h expected 84cc", {tr[0].j0, tr[0].k0, tr[0].j1, tr[0].k1});
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (tr[i] !== exq[i]) begin
                fails++;
                $display("FAIL encoding_trace cyc %0d: got %h expected %h", i, tr[i], exq[i]);
            end
        end
    endtask

    task automatic test_count();
        for (int i = 0; i < 8; i++) load(i, 4'(i + 1));
        set_bank(4'h0);
        kick(8, 0);
        capture(18);
        build(8, 0, 4'h0, 18);
        for (int i = 0; i < 18; i++) begin
            tests++;
            if (tr[i] !== exq[i]) begin
                fails++;
                $display("FAIL count cyc %0d: got %h expected %h", i, tr[i], exq[i]);
            end
        end
    endtask

    task automatic test_mismatch();
        load(0, 4'b0001);
        set_bank(4'h0);
        stuck = 4'b0001;
        kick(1, 0);
        tests++;
        if ({bif0.j_out, bif0.k_out, busy0} !== 9'b0001_0000_1) begin
            fails++;
            $display("FAIL mismatch_drive: got %b expected 000100001", {bif0.j_out, bif0.k_out, busy0});
        end
        tick();
        tick();
        tests++;
        if ({err0, busy0, done0, idx0, bif0.j_out, bif0.k_out} !== {3'b100, 3'd0, 8'h00}) begin
            fails++;
            $display("FAIL mismatch_end: got %b expected 10000000000000", {err0, busy0, done0, idx0, bif0.j_out, bif0.k_out});
        end
        tick();
        tests++;
        if ({err0, done0} !== 2'b10) begin
            fails++;
            $display("FAIL mismatch_sticky: got %b expected 10", {err0, done0});
        end
        stuck = 4'b0000;
        kick(1, 0);
        tests++;
        if ({err0, busy0} !== 2'b01) begin
            fails++;
            $display("FAIL mismatch_clear: got %b expected 01", {err0, busy0});
        end
        repeat (3) tick();
    endtask

    task automatic test_loop_stop();
        load(0, 4'd3);
        load(1, 4'd12);
        set_bank(4'h0);
        kick(2, 1);
        capture(7);
        build(2, 1, 4'h0, 7);
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (tr[i] !== exq[i]) begin
                fails++;
                $display("FAIL loop cyc %0d: got %h expected %h", i, tr[i], exq[i]);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tests++;
        if ({busy0, done0, err0, bif0.j_out, bif0.k_out, bif1.j_out, bif1.k_out} !== 19'b0) begin
            fails++;
            $display("FAIL stop: got %h expected 0", {busy0, done0, err0, bif0.j_out, bif0.k_out, bif1.j_out, bif1.k_out});
        end
        tick();
    endtask

    task automatic test_len_zero();
        kick(0, 0);
        tests++;
        if ({done0, busy0, bif0.j_out, bif0.k_out, bif1.j_out, bif1.k_out} !== {2'b10, 16'h0}) begin
            fails++;
            $display("FAIL len0_done: got %h expected 20000", {done0, busy0, bif0.j_out, bif0.k_out, bif1.j_out, bif1.k_out});
        end
        tick();
        tests++;
        if ({done0, busy0} !== 2'b00) begin
            fails++;
            $display("FAIL len0_after: got %b expected 00", {done0, busy0});
        end
    endtask

    task automatic test_len_clamp();
        logic [3:0] qi;
        for (int i = 0; i < 8; i++) load(i, 4'($urandom));
        qi = 4'($urandom);
        set_bank(qi);
        kick(15, 0);
        capture(18);
        build(15, 0, qi, 18);
        for (int i = 0; i < 18; i++) begin
            tests++;
            if (tr[i] !== exq[i]) begin
                fails++;
                $display("FAIL len15 cyc %0d: got %h expected %h", i, tr[i], exq[i]);
            end
        end
    endtask

    task automatic test_load_busy();
        logic [3:0] qi;
        int a;
        qi = 4'($urandom);
        set_bank(qi);
        kick(8, 0);
        a = $urandom_range(0, 7);
        load_en = 1'b1; load_addr = 3'(a); load_data = ~tbl_m[a];
        capture(15);
        load_en = 1'b0;
        repeat (3) tick();
        set_bank(qi);
        kick(8, 0);
        capture(18);
        build(8, 0, qi, 18);
        for (int i = 0; i < 18; i++) begin
            tests++;
            if (tr[i] !== exq[i]) begin
                fails++;
                $display("FAIL load_busy cyc %0d: got %h expected %h", i, tr[i], exq[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] qi;
        int ln;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) load(i, 4'($urandom));
            qi = 4'($urandom);
            ln = $urandom_range(1, 15);
            set_bank(qi);
            kick(ln, 0);
            capture(2 * (ln > 8 ? 8 : ln) + 2);
            build(ln, 0, qi, tr.size());
            for (int i = 0; i < tr.size(); i++) begin
                tests++;
                if (tr[i] !== exq[i]) begin
                    fails++;
                    $display("FAIL random r%0d cyc %0d: got %h expected %h", r, i, tr[i], exq[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        load(0, 4'hF);
        set_bank(4'h0);
        kick(8, 0);
        tests++;
        if ({bif0.j_out, busy0} !== 5'b1111_1) begin
            fails++;
            $display("FAIL areset_pre: got %b expected 11111", {bif0.j_out, busy0});
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({bif0.j_out, bif0.k_out, bif1.j_out, bif1.k_out, busy0, err0, idx0} !== 21'b0) begin
            fails++;
            $display("FAIL areset_now: got %h expected 0", {bif0.j_out, bif0.k_out, bif1.j_out, bif1.k_out, busy0, err0, idx0});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tbl_m[i] = 4'h0;
        set_bank(4'h5);
        kick(8, 0);
        capture(18);
        build(8, 0, 4'h5, 18);
        for (int i = 0; i < 18; i++) begin
            tests++;
            if (tr[i] !== exq[i]) begin
                fails++;
                $display("FAIL areset_table cyc %0d: got %h expected %h", i, tr[i], exq[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) tbl_m[i] = 4'h0;
        test_reset();
        test_encoding();
        test_count();
        test_mismatch();
        test_loop_stop();
        test_len_zero();
        test_len_clamp();
        test_load_busy();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
